// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Turns a stream of received UART bytes into board moves. A frame is four
//   bytes: HEADER, X, Y, CHK with CHK = HEADER ^ X ^ Y. A good, in-range frame
//   loads move_x/move_y and raises move_valid, which is held until the
//   consumer accepts it with move_ready. Bad frames produce one-cycle error
//   pulses one cycle after the CHK byte.
//
//   Optional feature macro: UART_CMD_TIMEOUT_EN
//     defined   - inter-byte timeout counter; a stalled partial frame is
//                 abandoned after TIMEOUT_CYC idle cycles and err_timeout pulses.
//     undefined - no counter, err_timeout tied low, partial frames wait forever.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-low reset
//   rx_data      in   received byte (DATA_WIDTH)
//   rx_done      in   one-cycle strobe qualifying rx_data
//   move_x       out  decoded column (4 bits)
//   move_y       out  decoded row (4 bits)
//   move_valid   out  move available, held until accepted
//   move_ready   in   consumer accepts when move_valid & move_ready
//   err_chk      out  pulse: checksum mismatch
//   err_range    out  pulse: coordinate outside the board
//   err_ovr      out  pulse: good frame dropped because a move is still held
//   err_timeout  out  pulse: inter-byte timeout
module uart_cmd_parser #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    BOARD_SIZE  = 15,
  parameter logic [DATA_WIDTH-1:0] HEADER      = 'hAA,
  parameter int                    TIMEOUT_CYC = 2_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_done,
  output logic [3:0]            move_x,
  output logic [3:0]            move_y,
  output logic                  move_valid,
  input  logic                  move_ready,
  output logic                  err_chk,
  output logic                  err_range,
  output logic                  err_ovr,
  output logic                  err_timeout
);

  typedef enum logic [1:0] {IDLE, GET_X, GET_Y, GET_CHK} state_t;

  localparam logic [DATA_WIDTH-1:0] BOARD_LIM = DATA_WIDTH'(BOARD_SIZE);

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] x_q, y_q;
  logic                  frame_good, chk_bad, range_bad, ovr, load_move, to_fire;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  logic [CNT_W-1:0] to_cnt;
`endif

  always_comb begin
    state_nxt  = state;
    frame_good = 1'b0;
    chk_bad    = 1'b0;
    range_bad  = 1'b0;
    to_fire    = 1'b0;
    if (rx_done) begin
      case (state)
        IDLE:    if (rx_data == HEADER) state_nxt = GET_X;
        GET_X:   state_nxt = GET_Y;
        GET_Y:   state_nxt = GET_CHK;
        default: begin
          state_nxt = IDLE;
          // Checksum has priority over the range check.
          if (rx_data != (HEADER ^ x_q ^ y_q))
            chk_bad = 1'b1;
          else if ((x_q >= BOARD_LIM) || (y_q >= BOARD_LIM))
            range_bad = 1'b1;
          else
            frame_good = 1'b1;
        end
      endcase
    end
`ifdef UART_CMD_TIMEOUT_EN
    // A byte arriving in the same cycle wins over the timeout.
    else if ((state != IDLE) && (to_cnt == CNT_W'(TIMEOUT_CYC - 1))) begin
      to_fire   = 1'b1;
      state_nxt = IDLE;
    end
`endif
    // A held move can be replaced only if it is being accepted this cycle.
    load_move = frame_good && (!move_valid || move_ready);
    ovr       = frame_good && move_valid && !move_ready;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      move_x     <= '0;
      move_y     <= '0;
      move_valid <= 1'b0;
      err_chk    <= 1'b0;
      err_range  <= 1'b0;
      err_ovr    <= 1'b0;
    end else begin
      state     <= state_nxt;
      err_chk   <= chk_bad;
      err_range <= range_bad;
      err_ovr   <= ovr;
      if (load_move) begin
        move_x     <= x_q[3:0];
        move_y     <= y_q[3:0];
        move_valid <= 1'b1;
      end else if (move_valid && move_ready) begin
        move_valid <= 1'b0;
      end
    end
  end

  // Coordinate capture is pure data; a stale value is never used because
  // a fresh HEADER/X/Y sequence always precedes the CHK byte.
  always_ff @(posedge clk) begin
    if (rx_done && (state == GET_X)) x_q <= rx_data;
    if (rx_done && (state == GET_Y)) y_q <= rx_data;
  end

`ifdef UART_CMD_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= to_fire;
      if (rx_done || (state == IDLE) || to_fire) to_cnt <= '0;
      else                                       to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign err_timeout = 1'b0;
`endif

endmodule
